// File: rtl/loctag_pkg.sv
// Shared types and helpers for the LocTag reflection slot scheduler.
package loctag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GUARD   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_REFLECT = 3'd3,
    ST_TAIL    = 3'd4
  } sched_state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Contention window W = 2^mac_q slots, returned as W-1 so it doubles as a slot mask.
  function automatic logic [2:0] window_mask(input logic [1:0] mac_q);
    logic [3:0] w;
    w = 4'd1 << mac_q;
    return 3'(w - 4'd1);
  endfunction

endpackage

// File: rtl/loctag_lfsr16.sv
// 16-bit Galois LFSR stepping every clock; a zero seed is promoted to 1 so it never locks up.
module loctag_lfsr16
  import loctag_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h7654
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = {1'b0, state_q[15:1]};
    if (state_q[0]) begin
      state_d = state_d ^ LFSR_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/loctag_slot_sched.sv
// Slotted random-access reflection scheduler driving the ctrl_1 reflector pin.
// Optional statistics counters are built when LOCTAG_SCHED_STATS_EN is defined.
module loctag_slot_sched
  import loctag_pkg::*;
#(
  parameter logic [15:0] MAC_SEED        = 16'h7654,
  parameter int          GUARD_CYCLES    = 50,
  parameter int          SLOT_CYCLES     = 500,
  parameter int          MOD_HALF_CYCLES = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig_pulse,
  input  logic        enable,
  input  logic [1:0]  mac_q,
  output logic        ctrl_1,
  output logic        busy,
  output logic [2:0]  slot_sel,
  output logic        done,
  output logic [15:0] served_cnt,
  output logic [15:0] drop_cnt
);

  localparam int CNT_N = (SLOT_CYCLES > GUARD_CYCLES) ? SLOT_CYCLES : GUARD_CYCLES;
  localparam int CNT_W = (CNT_N > 1) ? $clog2(CNT_N) : 1;
  localparam int MOD_W = (MOD_HALF_CYCLES > 1) ? $clog2(MOD_HALF_CYCLES) : 1;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [MOD_W-1:0] MOD_LAST   = MOD_W'(MOD_HALF_CYCLES - 1);

  logic [15:0]  lfsr_state;
  logic         lfsr_unused;

  sched_state_t state_q;
  logic [CNT_W-1:0] cyc_q;
  logic [2:0]   slot_cnt_q;
  logic [2:0]   slot_sel_q;
  logic [2:0]   win_mask_q;
  logic [MOD_W-1:0] mod_q;
  logic         ctrl_q;
  logic         busy_q;
  logic         done_q;

  loctag_lfsr16 #(
    .SEED (MAC_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_state)
  );

  // Only the low three bits pick a slot; the rest feed other consumers of the generator.
  assign lfsr_unused = ^lfsr_state[15:3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      slot_cnt_q <= '0;
      slot_sel_q <= '0;
      win_mask_q <= '0;
      mod_q      <= '0;
      ctrl_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != ST_IDLE) && !enable) begin
        // Abort: drop the reflector immediately and suppress the completion pulse.
        state_q <= ST_IDLE;
        ctrl_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trig_pulse && enable) begin
              slot_sel_q <= lfsr_state[2:0] & window_mask(mac_q);
              win_mask_q <= window_mask(mac_q);
              cyc_q      <= '0;
              slot_cnt_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= ST_GUARD;
            end
          end

          ST_GUARD: begin
            if (cyc_q == GUARD_LAST) begin
              cyc_q <= '0;
              if (slot_sel_q == 3'd0) begin
                state_q <= ST_REFLECT;
                ctrl_q  <= 1'b1;
                mod_q   <= '0;
              end else begin
                state_q <= ST_WAIT;
              end
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end

          ST_WAIT: begin
            if (cyc_q == SLOT_LAST) begin
              cyc_q      <= '0;
              slot_cnt_q <= slot_cnt_q + 3'd1;
              if ((slot_cnt_q + 3'd1) == slot_sel_q) begin
                state_q <= ST_REFLECT;
                ctrl_q  <= 1'b1;
                mod_q   <= '0;
              end
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end

          ST_REFLECT: begin
            if (cyc_q == SLOT_LAST) begin
              cyc_q  <= '0;
              ctrl_q <= 1'b0;
              done_q <= 1'b1;
              // Last-slot test precedes the increment so the 3-bit counter never wraps.
              if (slot_cnt_q == win_mask_q) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q    <= ST_TAIL;
                slot_cnt_q <= slot_cnt_q + 3'd1;
              end
            end else begin
              cyc_q <= cyc_q + 1'b1;
              if (mod_q == MOD_LAST) begin
                mod_q  <= '0;
                ctrl_q <= ~ctrl_q;
              end else begin
                mod_q <= mod_q + 1'b1;
              end
            end
          end

          ST_TAIL: begin
            if (cyc_q == SLOT_LAST) begin
              cyc_q <= '0;
              if (slot_cnt_q == win_mask_q) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                slot_cnt_q <= slot_cnt_q + 3'd1;
              end
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            ctrl_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ctrl_1   = ctrl_q;
  assign busy     = busy_q;
  assign slot_sel = slot_sel_q;
  assign done     = done_q;

`ifdef LOCTAG_SCHED_STATS_EN
  logic [15:0] served_q;
  logic [15:0] drop_q;
  logic        drop_ev;

  assign drop_ev = (state_q != ST_IDLE) && trig_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      served_q <= '0;
      drop_q   <= '0;
    end else begin
      if (done_q && (served_q != 16'hFFFF)) begin
        served_q <= served_q + 16'd1;
      end
      if (drop_ev && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign served_cnt = served_q;
  assign drop_cnt   = drop_q;
`else
  assign served_cnt = '0;
  assign drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_loctag_slot_sched.sv
// Randomized self-checking bench for loctag_slot_sched against a cycle-count reference model.
module tb_loctag_slot_sched;

  localparam int G = 50;
  localparam int S = 500;
  localparam int H = 25;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trig_pulse = 1'b0;
  logic        enable = 1'b1;
  logic [1:0]  mac_q = 2'd0;
  logic        ctrl_1;
  logic        busy;
  logic [2:0]  slot_sel;
  logic        done;
  logic [15:0] served_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] lfsr0_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_lfsr;
  int          m_served = 0;
  int          m_drops  = 0;

  loctag_slot_sched #(
    .MAC_SEED        (16'h7654),
    .GUARD_CYCLES    (G),
    .SLOT_CYCLES     (S),
    .MOD_HALF_CYCLES (H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trig_pulse (trig_pulse),
    .enable     (enable),
    .mac_q      (mac_q),
    .ctrl_1     (ctrl_1),
    .busy       (busy),
    .slot_sel   (slot_sel),
    .done       (done),
    .served_cnt (served_cnt),
    .drop_cnt   (drop_cnt)
  );

  loctag_lfsr16 #(
    .SEED (16'h0000)
  ) u_lfsr0 (
    .clk   (clk),
    .reset (reset),
    .state (lfsr0_state)
  );

  always #10 clk = ~clk;

  // Reference random source: Galois shift right, fold in 0xB400 when a one drops out.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'h7654;
    else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_stats();
`ifdef LOCTAG_SCHED_STATS_EN
    check("served_cnt", served_cnt, m_served);
    check("drop_cnt", drop_cnt, m_drops);
`else
    check("served_cnt_off", served_cnt, 0);
    check("drop_cnt_off", drop_cnt, 0);
`endif
  endtask

  // One trigger, then every cycle compared against the window timeline derived from k and W.
  task automatic run_window(input int mq, input int busy_at, input bit rnd_trig, input int abort_at);
    int w, k, rs, end_i, last_i, drops_here;
    bit exp_busy, exp_ctrl, exp_done;
    w      = 1 << mq;
    k      = int'(m_lfsr[2:0]) & (w - 1);
    rs     = 1 + G + k * S;
    end_i  = 1 + G + w * S;
    last_i = (abort_at > 0) ? abort_at + 4 : end_i + 1;
    drops_here = 0;
    check("lfsr_sync", dut.u_lfsr.state, m_lfsr);
    mac_q      = 2'(mq);
    enable     = 1'b1;
    trig_pulse = 1'b1;
    tick(1);
    trig_pulse = 1'b0;
    for (int i = 1; i <= last_i; i++) begin
      if (abort_at > 0 && i > abort_at) begin
        exp_busy = 1'b0;
        exp_ctrl = 1'b0;
        exp_done = 1'b0;
      end else begin
        exp_busy = (i < end_i);
        exp_ctrl = (i >= rs) && (i < rs + S) && ((((i - rs) / H) % 2) == 0);
        exp_done = (i == rs + S);
      end
      check("busy", busy, exp_busy);
      check("ctrl_1", ctrl_1, exp_ctrl);
      check("done", done, exp_done);
      check("slot_sel", slot_sel, k);
      mac_q      = 2'($urandom_range(0, 3));
      trig_pulse = (i == busy_at) || (rnd_trig && (i < end_i - 1) && ($urandom_range(0, 799) == 0));
      if (abort_at > 0 && i >= abort_at) enable = 1'b0;
      if (trig_pulse && exp_busy) drops_here++;
      tick(1);
    end
    trig_pulse = 1'b0;
    enable     = 1'b1;
    if (abort_at == 0) m_served = (m_served >= 65535) ? 65535 : m_served + 1;
    m_drops = (m_drops + drops_here > 65535) ? 65535 : m_drops + drops_here;
    check_stats();
    $display("window mac_q=%0d slot=%0d drops=%0d abort_at=%0d served_model=%0d",
             mq, k, drops_here, abort_at, m_served);
  endtask

  initial begin
    reset = 1'b1;
    tick(3);
    check("rst_ctrl_1", ctrl_1, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_slot_sel", slot_sel, 0);
    check("rst_lfsr_seed", dut.u_lfsr.state, 16'h7654);
    check("rst_lfsr_zero_seed", lfsr0_state, 16'h0001);
    check_stats();
    $display("reset sequence done");
    reset = 1'b0;
    tick(2);

    run_window(0, 0, 1'b0, 0);
    tick($urandom_range(0, 6));
    run_window(3, 0, 1'b0, 0);
    tick($urandom_range(0, 6));
    run_window(1, 300, 1'b0, 0);
    tick($urandom_range(0, 6));
    run_window(2, 300, 1'b1, 0);
    for (int r = 0; r < 4; r++) begin
      tick($urandom_range(0, 9));
      run_window(int'($urandom_range(0, 3)), 0, 1'b1, 0);
    end
    tick(3);
    run_window(0, 0, 1'b0, 200);

    // Trigger with enable low in IDLE: no start and nothing counted as dropped.
    tick(2);
    enable     = 1'b0;
    trig_pulse = 1'b1;
    tick(1);
    trig_pulse = 1'b0;
    enable     = 1'b1;
    check("idle_disabled_busy", busy, 0);
    tick(1);
    check("idle_disabled_busy2", busy, 0);
    check_stats();
    $display("idle trigger with enable low");

    // Reset in the middle of a window.
    mac_q      = 2'd3;
    trig_pulse = 1'b1;
    tick(1);
    trig_pulse = 1'b0;
    tick(700);
    reset = 1'b1;
    tick(1);
    m_served = 0;
    m_drops  = 0;
    check("midrst_ctrl_1", ctrl_1, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_slot_sel", slot_sel, 0);
    check("midrst_lfsr", dut.u_lfsr.state, 16'h7654);
    check_stats();
    reset = 1'b0;
    tick(2);
    $display("reset during active window");

`ifdef LOCTAG_SCHED_STATS_EN
    force dut.served_q = 16'hFFFF;
    tick(1);
    release dut.served_q;
    m_served = 65535;
    run_window(0, 0, 1'b0, 0);
    check("served_saturated", served_cnt, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/loctag_slot_sched.md
# loctag_slot_sched

Reflection slot scheduler for the LocTag backscatter path. On each smoothed trigger from the detector it picks a random reflection slot inside a contention window sized by `mac_q`, waits a guard interval, then drives the reflector control (`ctrl_1`) with a square-wave modulation for exactly one slot. It sits between the trigger-smoothing logic and the `ctrl_1` reflector pin inside `loctag`, replacing free-running reflection with slotted random access, so that several tags can share one reader.

## Interface
Parameters:
- `MAC_SEED`, 16'h7654: LFSR seed. A seed of 0 is replaced by 16'h0001.
- `GUARD_CYCLES`, 50: delay from trigger to the start of slot 0 (1 µs at 50 MHz).
- `SLOT_CYCLES`, 500: slot length in clocks.
- `MOD_HALF_CYCLES`, 25: `ctrl_1` half-period in clocks.

Ports:
- `clk`  in  1: 50 MHz system clock.
- `reset`  in  1: synchronous, active-high.
- `trig_pulse`  in  1: one-cycle pulse per smoothed trigger edge.
- `enable`  in  1: scheduler enable (reflect modes).
- `mac_q`  in  2: window exponent. Window W = 2^mac_q slots (1, 2, 4 or 8).
- `ctrl_1`  out  1: reflector drive.
- `busy`  out  1: high in every state except IDLE.
- `slot_sel`  out  3: slot chosen for the current window.
- `done`  out  1: one-cycle pulse when a reflection slot completes normally.
- `served_cnt`  out  16: number of completed reflections. Only active under the stats macro.
- `drop_cnt`  out  16: number of triggers ignored while busy. Only active under the stats macro.

## Operation
- **LFSR:** 16-bit Galois LFSR with mask 16'hB400. It steps every clock out of reset. The slot choice is `lfsr[2:0] & (W-1)`.
- **States:** IDLE, GUARD, WAIT, REFLECT, TAIL.
- **IDLE:**
  - A `trig_pulse` while `enable`=1 latches `slot_sel`, W and `mac_q`.
  - Clears the cycle counter and the slot counter, then moves to GUARD.
- **GUARD:** runs for GUARD_CYCLES cycles. Then moves to REFLECT if `slot_sel`=0, else to WAIT.
- **WAIT:**
  - The slot counter increments every SLOT_CYCLES cycles.
  - When the count equals `slot_sel`, the block moves to REFLECT.
- **REFLECT:**
  - Lasts SLOT_CYCLES cycles.
  - `ctrl_1` is 1 in the first cycle and toggles every MOD_HALF_CYCLES cycles.
  - On exit, `ctrl_1` goes to 0 and `done` pulses for one cycle.
  - Moves to TAIL if slots remain in the window, else to IDLE.
- **TAIL:** idles, with `ctrl_1`=0, until the end of slot W-1, then moves to IDLE.
- **Triggers while busy:** a `trig_pulse` in any non-IDLE state is ignored and increments `drop_cnt`.
- **Disable:** `enable`=0 in any non-IDLE state aborts to IDLE on the next cycle. `ctrl_1` is 0 from that cycle and `done` does not pulse.
- **`mac_q` changes:** ignored mid-window; the value latched at the trigger governs the whole window.
- **Counters:** sized `$clog2(SLOT_CYCLES)`. The slot counter is 3 bits and never wraps, because the exit condition is checked first.

## Timing
- **Reset values:** `ctrl_1`=0, `busy`=0, `slot_sel`=0, `done`=0, counters=0, LFSR=seed, state=IDLE.
- **All outputs are registered.** For a trigger sampled at edge T:
  - `busy` is high from T+1.
  - REFLECT starts at T+1+GUARD_CYCLES+`slot_sel`·SLOT_CYCLES. `ctrl_1` is 1 in that cycle.
  - `done` is high in the first cycle after the last REFLECT cycle.
  - `busy` falls at T+1+GUARD_CYCLES+W·SLOT_CYCLES.
- **Retrigger:** a new trigger is accepted no earlier than the first IDLE cycle.
- **Same-cycle `trig_pulse` and `enable`=0 in IDLE:** no start and no drop count.
- **Reset during any state:** all outputs return to reset values on the next edge.

## Configuration
- **`LOCTAG_SCHED_STATS_EN` defined:**
  - `served_cnt` increments on each `done`.
  - `drop_cnt` increments on each ignored trigger.
  - Both counters saturate at 16'hFFFF and clear on reset.
- **`LOCTAG_SCHED_STATS_EN` undefined:** both ports are constant 0 and no counter flops are synthesised.

## Structure
- **Package `loctag_pkg`:**
  - State enum `sched_state_t`.
  - `LFSR_MASK` = 16'hB400.
  - Function `window_mask(mac_q)`, which returns `(1<<mac_q)-1`.
- **Sub-module `loctag_lfsr16`:** ports `clk`, `reset`, seed parameter, 16-bit `state` output. It is reused later for tag-ID dithering.

## Test plan
- **Reset check:** assert `reset` for 3 cycles. Expect `ctrl_1`=`busy`=`done`=0 and the LFSR state equal to 16'h7654. A seed of 0 yields 16'h0001.
- **Single-slot window:** `mac_q`=0, trigger at T. Expect:
  - `ctrl_1` rises at T+51.
  - 20 half-periods of 25 cycles.
  - `done` at T+551.
  - `busy` falls at T+551.
- **Eight-slot window:** `mac_q`=3, with the expected slot k taken from the LFSR model. Expect:
  - REFLECT at T+51+500k.
  - `busy` falls at T+4051.
  - `slot_sel`=k throughout.
- **Trigger while busy:** trigger at T+300 during GUARD/WAIT. Expect the timing to be unchanged, `drop_cnt` to go 0→1 with the macro, and `drop_cnt`=0 without it.
- **Abort:** drop `enable` mid-REFLECT at cycle R. Expect `ctrl_1`=0 and `busy`=0 at R+1, and no `done`.
- **Stats saturation:** with the macro, force `served_cnt` to 16'hFFFF and complete one reflection. Expect the count to stay at 16'hFFFF.
